seven_segment_scanner: RTL and testbench



---
 rtl/seven_segment_scanner.sv | 150 +++++++++++++++
 tb/tb_seven_segment_scanner.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed driver for a common-anode
// seven-segment display. The value and dp inputs are captured into a shadow
// register, and one digit is scanned per refresh slot. The first cycle of each
// slot is a blank dead-time cycle that prevents ghosting between digits.
// All outputs are registered and active-low.
// Optional feature: define SEVSEG_LEADING_ZERO_BLANK_EN to blank leading zero
// digits. Digit 0 is never blanked.
module seven_segment_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int HEX_MODE    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int P_W   = $clog2(REFRESH_DIV);
    localparam logic [P_W-1:0]   P_LAST   = P_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [P_W-1:0]          p;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    wrapped;

    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [6:0]            seg_next;
    logic                  dp_n_next;
    logic [NUM_DIGITS-1:0] an_next;
    logic                  frame_done_next;

    // Active-low glyph table (abcdefg). Codes 10-15 are blank unless hex glyphs are enabled.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'd0:    g = 7'b0000001;
            4'd1:    g = 7'b1001111;
            4'd2:    g = 7'b0010010;
            4'd3:    g = 7'b0000110;
            4'd4:    g = 7'b1001100;
            4'd5:    g = 7'b0100100;
            4'd6:    g = 7'b0100000;
            4'd7:    g = 7'b0001111;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0000100;
            4'd10:   g = (HEX_MODE != 0) ? 7'b0001000 : 7'b1111111;
            4'd11:   g = (HEX_MODE != 0) ? 7'b1100000 : 7'b1111111;
            4'd12:   g = (HEX_MODE != 0) ? 7'b0110001 : 7'b1111111;
            4'd13:   g = (HEX_MODE != 0) ? 7'b1000010 : 7'b1111111;
            4'd14:   g = (HEX_MODE != 0) ? 7'b0110000 : 7'b1111111;
            default: g = (HEX_MODE != 0) ? 7'b0111000 : 7'b1111111;
        endcase
        return g;
    endfunction

    // Select the shadow nibble and dp bit for the active digit, and build the one-cold anode pattern.
    always_comb begin
        cur_nibble = 4'd0;
        cur_dp     = 1'b0;
        an_sel     = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nibble = shadow_value[i*4 +: 4];
                cur_dp     = shadow_dp[i];
                an_sel[i]  = 1'b0;
            end
        end
    end

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    // Blank the active digit when it and every more significant digit are zero with no dp lit.
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        cur_blank = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (shadow_value[i*4 +: 4] == 4'd0) && !shadow_dp[i];
            if ((i != 0) && (idx == IDX_W'(i)) && all_zero) begin
                cur_blank = 1'b1;
            end
        end
    end
`else
    // Without leading-zero blanking, every digit is driven.
    always_comb begin
        cur_blank = 1'b0;
    end
`endif

    // Next output values: dead time on the first cycle of a slot, otherwise drive the active digit.
    always_comb begin
        seg_next        = 7'b1111111;
        dp_n_next       = 1'b1;
        an_next         = '1;
        frame_done_next = (p == '0) && (idx == '0) && wrapped;
        if ((p != '0) && !cur_blank) begin
            seg_next  = glyph(cur_nibble);
            dp_n_next = ~cur_dp;
            an_next   = an_sel;
        end
    end

    // Prescaler, digit index, shadow capture and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            p            <= '0;
            idx          <= '0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            wrapped      <= 1'b0;
            seg          <= 7'b1111111;
            dp_n         <= 1'b1;
            an           <= '1;
            frame_done   <= 1'b0;
        end else begin
            if (p == P_LAST) begin
                p <= '0;
                if (idx == IDX_LAST) begin
                    idx     <= '0;
                    wrapped <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                p <= p + 1'b1;
            end
            if (load) begin
                shadow_value <= value;
                shadow_dp    <= dp;
            end
            seg        <= seg_next;
            dp_n       <= dp_n_next;
            an         <= an_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed test of the scanner with four digits and
// four cycles per slot. Two instances run in parallel, one with decimal glyphs
// only and one with hex glyphs. Expectations for leading-zero blanking follow
// SEVSEG_LEADING_ZERO_BLANK_EN.
module tb_seven_segment_scanner;

    localparam logic [6:0] G_0   = 7'b0000001;
    localparam logic [6:0] G_1   = 7'b1001111;
    localparam logic [6:0] G_2   = 7'b0010010;
    localparam logic [6:0] G_3   = 7'b0000110;
    localparam logic [6:0] G_4   = 7'b1001100;
    localparam logic [6:0] G_5   = 7'b0100100;
    localparam logic [6:0] G_9   = 7'b0000100;
    localparam logic [6:0] G_A   = 7'b0001000;
    localparam logic [6:0] G_C   = 7'b0110001;
    localparam logic [6:0] G_F   = 7'b0111000;
    localparam logic [6:0] G_OFF = 7'b1111111;
    localparam logic [12:0] DEAD = {7'b1111111, 4'b1111, 1'b1, 1'b0};

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] BLANK_0050 = 4'b1100;
    localparam logic [3:0] BLANK_0000 = 4'b1110;
`else
    localparam logic [3:0] BLANK_0050 = 4'b0000;
    localparam logic [3:0] BLANK_0000 = 4'b0000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;

    logic [6:0] seg_dec, seg_hex;
    logic       dp_n_dec, dp_n_hex;
    logic [3:0] an_dec, an_hex;
    logic       fd_dec, fd_hex;

    int assert_count = 0;
    int fail_count   = 0;

    seven_segment_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(0)) u_dut_dec (
        .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
        .seg(seg_dec), .dp_n(dp_n_dec), .an(an_dec), .frame_done(fd_dec)
    );

    seven_segment_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1)) u_dut_hex (
        .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
        .seg(seg_hex), .dp_n(dp_n_hex), .an(an_hex), .frame_done(fd_hex)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Watchdog so that a stuck run still ends with a failure report.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d);
        reset = r;
        load  = l;
        value = v;
        dp    = d;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [12:0] observed, input logic [12:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed seg=%b an=%b dp_n=%b fd=%b, expected seg=%b an=%b dp_n=%b fd=%b",
                   tag, observed[12:6], observed[5:2], observed[1], observed[0],
                   expected[12:6], expected[5:2], expected[1], expected[0]);
        end
    endtask

    task automatic checkBoth(input string tag, input logic [12:0] exp_dec, input logic [12:0] exp_hex);
        checkOutput({tag, " dec"}, {seg_dec, an_dec, dp_n_dec, fd_dec}, exp_dec);
        checkOutput({tag, " hex"}, {seg_hex, an_hex, dp_n_hex, fd_hex}, exp_hex);
    endtask

    // Steps through one 16-cycle frame starting on digit 0's dead-time cycle.
    task automatic checkFrame(input string tag, input logic [27:0] segs_dec, input logic [27:0] segs_hex,
                              input logic [3:0] blank_mask, input logic [3:0] dp_bits, input logic fd_first);
        logic [12:0] exp_dec;
        logic [12:0] exp_hex;
        logic [3:0]  an_exp;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                stepEdge();
                an_exp = ~(4'b0001 << s);
                if (c == 0) begin
                    exp_dec = {7'b1111111, 4'b1111, 1'b1, (s == 0) ? fd_first : 1'b0};
                    exp_hex = exp_dec;
                end else if (blank_mask[s]) begin
                    exp_dec = DEAD;
                    exp_hex = DEAD;
                end else begin
                    exp_dec = {segs_dec[s*7 +: 7], an_exp, ~dp_bits[s], 1'b0};
                    exp_hex = {segs_hex[s*7 +: 7], an_exp, ~dp_bits[s], 1'b0};
                end
                checkBoth($sformatf("%s s%0d c%0d", tag, s, c), exp_dec, exp_hex);
            end
        end
    endtask

    // Directed sequence of steps.
    initial begin
        applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0);
        repeat (2) begin
            stepEdge();
            checkBoth("reset", DEAD, DEAD);
        end
        // A load during reset must be ignored; otherwise digit 0 would later show 8.
        applyStimulus(1'b1, 1'b1, 16'h8888, 4'hF);
        stepEdge();
        checkBoth("reset load ignored", DEAD, DEAD);

        applyStimulus(1'b0, 1'b0, 16'h8888, 4'hF);
        stepEdge();
        checkBoth("first dead", DEAD, DEAD);
        for (int k = 0; k < 3; k++) begin
            stepEdge();
            checkBoth($sformatf("first digit0 c%0d", k + 1), {G_0, 4'b1110, 1'b1, 1'b0}, {G_0, 4'b1110, 1'b1, 1'b0});
        end

        // Load 4321 with dp on digit 2; the load edge is digit 1's dead-time cycle.
        applyStimulus(1'b0, 1'b1, 16'h4321, 4'b0100);
        stepEdge();
        checkBoth("load edge dead", DEAD, DEAD);
        applyStimulus(1'b0, 1'b0, 16'h4321, 4'b0100);
        for (int k = 0; k < 11; k++) begin
            stepEdge();
            checkOutput($sformatf("no fd first frame %0d", k), {12'h000, fd_dec}, 13'h0000);
        end
        checkFrame("scan 4321 a", {G_4, G_3, G_2, G_1}, {G_4, G_3, G_2, G_1}, 4'b0000, 4'b0100, 1'b1);
        checkFrame("scan 4321 b", {G_4, G_3, G_2, G_1}, {G_4, G_3, G_2, G_1}, 4'b0000, 4'b0100, 1'b1);

        // Hex codes: the decimal instance blanks codes 10-15 but keeps the anode asserted.
        applyStimulus(1'b0, 1'b1, 16'hFA0C, 4'h0);
        stepEdge();
        checkBoth("hex load edge", {DEAD[12:1], 1'b1}, {DEAD[12:1], 1'b1});
        applyStimulus(1'b0, 1'b0, 16'hFA0C, 4'h0);
        repeat (15) stepEdge();
        checkFrame("hex FA0C", {G_OFF, G_OFF, G_0, G_OFF}, {G_F, G_A, G_0, G_C}, 4'b0000, 4'b0000, 1'b1);

        // Mid-slot load: old glyph after the load edge, new glyph after the following edge.
        repeat (2) stepEdge();
        applyStimulus(1'b0, 1'b1, 16'h9999, 4'h0);
        stepEdge();
        checkBoth("load edge old data", {G_OFF, 4'b1110, 1'b1, 1'b0}, {G_C, 4'b1110, 1'b1, 1'b0});
        applyStimulus(1'b0, 1'b0, 16'h1111, 4'h0);
        stepEdge();
        checkBoth("load latency new data", {G_9, 4'b1110, 1'b1, 1'b0}, {G_9, 4'b1110, 1'b1, 1'b0});
        repeat (2) stepEdge();
        checkBoth("value without load", {G_9, 4'b1101, 1'b1, 1'b0}, {G_9, 4'b1101, 1'b1, 1'b0});

        // Reset sampled at idx=2, p=2 aborts the frame.
        repeat (4) stepEdge();
        applyStimulus(1'b1, 1'b0, 16'h1111, 4'h0);
        stepEdge();
        checkBoth("mid-frame reset", DEAD, DEAD);
        applyStimulus(1'b0, 1'b0, 16'h1111, 4'h0);
        checkFrame("restart", {G_0, G_0, G_0, G_0}, {G_0, G_0, G_0, G_0}, BLANK_0000, 4'b0000, 1'b0);

        // Leading zeros with load held high, so the shadow tracks value every cycle.
        applyStimulus(1'b0, 1'b1, 16'h0050, 4'h0);
        checkFrame("zeros 0050", {G_0, G_0, G_5, G_0}, {G_0, G_0, G_5, G_0}, BLANK_0050, 4'b0000, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0000, 4'h0);
        checkFrame("zeros 0000", {G_0, G_0, G_0, G_0}, {G_0, G_0, G_0, G_0}, BLANK_0000, 4'b0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
